mp_register_file: RTL and testbench

Parametrised multi-port register file for the dual/multi-issue MIPS core. It generalises the fixed 2-write/4-read file to N_READ read ports and N_WRITE write ports, with configurable width and depth.
- Optional same-cycle write-to-read bypass.
- Deterministic write-port priority.
- Registered write-collision flag.
- Per-register busy scoreboard, used by issue logic for RAW hazard detection.

Sits between decode/issue (read and reserve) and writeback (write).

---
 rtl/rf_pkg.sv | 14 +
 rtl/mp_register_file_if.sv | 34 +++
 rtl/rf_write_arbiter.sv | 49 ++++
 rtl/mp_register_file.sv | 105 ++++++++++
 tb/tb_mp_register_file.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package rf_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;
  localparam int REG_ZERO       = 0;

  // Low bit of port idx inside a flattened bus of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mp_register_file_if.sv
// Read/write/reserve bus of the register file. The issue/writeback side is
// the master, the register file is the slave.
interface mp_register_file_if
  import rf_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int N_READ  = 4,
  parameter int N_WRITE = 2
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [N_READ*ADDR_W-1:0]  rd_addr;
  logic [N_READ*DATA_W-1:0]  rd_data;
  logic [N_READ-1:0]         rd_busy;
  logic [N_WRITE-1:0]        wr_en;
  logic [N_WRITE*ADDR_W-1:0] wr_addr;
  logic [N_WRITE*DATA_W-1:0] wr_data;
  logic [N_WRITE-1:0]        rsv_en;
  logic [N_WRITE*ADDR_W-1:0] rsv_addr;
  logic [NREGS-1:0]          busy_vec;
  logic                      wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec, wr_conflict
  );

endinterface

// File: rtl/rf_write_arbiter.sv
// Per-register write selection: the highest-index enabled port addressing
// this register wins; a second hit on a non-zero register flags a collision.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int N_WRITE  = 2,
  parameter int REG_IDX  = 0,
  parameter int ZERO_REG = 1
) (
  input  logic [N_WRITE-1:0]        wr_en_i,
  input  logic [N_WRITE*ADDR_W-1:0] wr_addr_i,
  input  logic [N_WRITE*DATA_W-1:0] wr_data_i,
  output logic                      we_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      clr_busy_o,
  output logic                      collide_o
);
  localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(REG_IDX);
  // A hardwired zero register must never be written (nor have busy cleared).
  localparam bit WRITABLE   = !((ZERO_REG != 0) && (REG_IDX == REG_ZERO));
  // Address 0 never counts as a collision, whatever ZERO_REG says.
  localparam bit COLLIDABLE = (REG_IDX != REG_ZERO);

  logic              hit_any;
  logic              hit_multi;
  logic [DATA_W-1:0] sel_data;

  // Scan ports low to high so the last (highest-index) match wins.
  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < N_WRITE; j++) begin
      if (wr_en_i[j] && (wr_addr_i[slice_lo(j, ADDR_W) +: ADDR_W] == MY_ADDR)) begin
        hit_multi = hit_multi | hit_any;
        hit_any   = 1'b1;
        sel_data  = wr_data_i[slice_lo(j, DATA_W) +: DATA_W];
      end
    end
  end

  assign we_o       = WRITABLE && hit_any;
  assign data_o     = sel_data;
  assign clr_busy_o = we_o;
  assign collide_o  = COLLIDABLE && hit_multi;

endmodule

// File: rtl/mp_register_file.sv
// Multi-port register file with optional write bypass, busy scoreboard for
// RAW hazard detection and a registered write-collision flag.
module mp_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int N_READ   = 4,
  parameter int N_WRITE  = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               reset,
  mp_register_file_if.slave rf
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              conflict_q;

  logic [NREGS-1:0]  we_vec, clr_vec, col_vec, set_vec;
  logic [DATA_W-1:0] wdata [NREGS];

  genvar gi;

  // One arbiter per register resolves port priority and collisions.
  for (gi = 0; gi < NREGS; gi++) begin : g_arb
    rf_write_arbiter #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .N_WRITE (N_WRITE),
      .REG_IDX (gi),
      .ZERO_REG(ZERO_REG)
    ) u_arb (
      .wr_en_i   (rf.wr_en),
      .wr_addr_i (rf.wr_addr),
      .wr_data_i (rf.wr_data),
      .we_o      (we_vec[gi]),
      .data_o    (wdata[gi]),
      .clr_busy_o(clr_vec[gi]),
      .collide_o (col_vec[gi])
    );
  end

  // Reserve decode: any reserve port naming a register marks it pending.
  always_comb begin
    set_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int j = 0; j < N_WRITE; j++) begin
        if (rf.rsv_en[j] && (rf.rsv_addr[slice_lo(j, ADDR_W) +: ADDR_W] == ADDR_W'(r)))
          set_vec[r] = 1'b1;
      end
      if ((ZERO_REG != 0) && (r == REG_ZERO))
        set_vec[r] = 1'b0;
    end
  end

  // Scoreboard next state: a new reservation beats a completing write.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (set_vec[r])
        busy_d[r] = 1'b1;
      else if (clr_vec[r])
        busy_d[r] = 1'b0;
    end
  end

  // Register storage; async clear so reset is visible without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (we_vec[r]) regs_q[r] <= wdata[r];
    end
  end

  // Busy scoreboard and collision pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= |col_vec;
    end
  end

  assign rf.busy_vec    = busy_q;
  assign rf.wr_conflict = conflict_q;

  // Read ports: the arbiter's per-register selection doubles as the bypass.
  for (gi = 0; gi < N_READ; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;
    assign ra  = rf.rd_addr[gi*ADDR_W +: ADDR_W];
    assign byp = (BYPASS != 0) && we_vec[ra];
    assign rf.rd_data[gi*DATA_W +: DATA_W] = byp ? wdata[ra] : regs_q[ra];
    assign rf.rd_busy[gi] = busy_q[ra] && !byp;
  end

endmodule

// File: tb/tb_mp_register_file.sv
// Bench for mp_register_file: a bypassing and a non-bypassing instance share
// the same stimulus; registered expectations go through a queue.
module tb_mp_register_file;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mp_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW)) bp_if ();
  mp_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW)) nb_if ();

  assign nb_if.rd_addr  = bp_if.rd_addr;
  assign nb_if.wr_en    = bp_if.wr_en;
  assign nb_if.wr_addr  = bp_if.wr_addr;
  assign nb_if.wr_data  = bp_if.wr_data;
  assign nb_if.rsv_en   = bp_if.rsv_en;
  assign nb_if.rsv_addr = bp_if.rsv_addr;

  mp_register_file #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW),
                     .BYPASS(1), .ZERO_REG(1))
    dut_bp (.clk(clk), .reset(reset), .rf(bp_if.slave));

  mp_register_file #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW),
                     .BYPASS(0), .ZERO_REG(1))
    dut_nb (.clk(clk), .reset(reset), .rf(nb_if.slave));

  typedef struct {
    string       name;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  ren;
    logic [4:0]  ra0, ra1;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1, d0_nb;
    logic        b0, b0_nb;
    logic [31:0] busy_after;
    logic        conf_after;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] busy;
    logic        conf;
  } post_t;

  localparam int NV = 14;
  vec_t  vecs [NV];
  post_t exp_q [$];
  post_t e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] r3);
    bp_if.wr_en    = wen;
    bp_if.wr_addr  = {wa1, wa0};
    bp_if.wr_data  = {wd1, wd0};
    bp_if.rsv_en   = ren;
    bp_if.rsv_addr = {ra1, ra0};
    bp_if.rd_addr  = {r3, r2, r1, r0};
  endtask

  function automatic logic [31:0] bp_rd(input int p);
    return bp_if.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [31:0] nb_rd(input int p);
    return nb_if.rd_data[p*DW +: DW];
  endfunction

  initial begin
    vecs[0]  = '{"wr r5 same-cycle", 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{"rd r5 next", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd5, 5'd9, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{"collide r9", 2'b11, 5'd9, 5'd9, 32'h11111111, 32'h22222222, 2'b00, 5'd0, 5'd0,
                 5'd9, 5'd5, 32'h22222222, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[3]  = '{"after collide", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd9, 5'd0, 32'h22222222, 32'h0, 32'h22222222, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{"collide r0", 2'b11, 5'd0, 5'd0, 32'h11111111, 32'h22222222, 2'b00, 5'd0, 5'd0,
                 5'd0, 5'd9, 32'h0, 32'h22222222, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{"rd r0 after", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{"rsv r3", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd3, 5'd0,
                 5'd3, 5'd9, 32'h0, 32'h22222222, 32'h0, 1'b0, 1'b0, 32'h8, 1'b0};
    vecs[7]  = '{"busy r3", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd3, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0};
    vecs[8]  = '{"wr+rsv r3", 2'b10, 5'd0, 5'd3, 32'h0, 32'h33333333, 2'b01, 5'd3, 5'd0,
                 5'd3, 5'd3, 32'h33333333, 32'h33333333, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0};
    vecs[9]  = '{"wr r3 clears", 2'b01, 5'd3, 5'd0, 32'h44444444, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd3, 5'd9, 32'h44444444, 32'h22222222, 32'h33333333, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[10] = '{"dual rsv r7", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd7, 5'd7,
                 5'd7, 5'd3, 32'h0, 32'h44444444, 32'h0, 1'b0, 1'b0, 32'h80, 1'b0};
    vecs[11] = '{"wr busy r7", 2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd7, 5'd3, 32'hA5A5A5A5, 32'h44444444, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[12] = '{"rsv r0", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd0, 5'd0,
                 5'd0, 5'd7, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{"distinct r30 r31", 2'b11, 5'd30, 5'd31, 32'h12345678, 32'h0BADF00D, 2'b00, 5'd0, 5'd0,
                 5'd31, 5'd30, 32'h0BADF00D, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};

    // Reset state, visible before any clock edge.
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd1, 5'd17, 5'd31);
    #1;
    for (int p = 0; p < NR; p++) check($sformatf("reset rd_data%0d", p), bp_rd(p), 32'h0);
    check("reset rd_busy", {28'h0, bp_if.rd_busy}, 32'h0);
    check("reset busy_vec", bp_if.busy_vec, 32'h0);
    check("reset wr_conflict", {31'h0, bp_if.wr_conflict}, 32'h0);
    $display("txn reset: rd ports 0,1,17,31");

    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].wen, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
            vecs[i].ren, vecs[i].ra0, vecs[i].ra1,
            vecs[i].rd0, vecs[i].rd1, vecs[i].rd0, vecs[i].rd1);
      #1;
      check({vecs[i].name, " d0"}, bp_rd(0), vecs[i].d0);
      check({vecs[i].name, " d1"}, bp_rd(1), vecs[i].d1);
      check({vecs[i].name, " d3"}, bp_rd(3), vecs[i].d1);
      check({vecs[i].name, " d0 nobypass"}, nb_rd(0), vecs[i].d0_nb);
      check({vecs[i].name, " busy0"}, {31'h0, bp_if.rd_busy[0]}, {31'h0, vecs[i].b0});
      check({vecs[i].name, " busy0 nobypass"}, {31'h0, nb_if.rd_busy[0]}, {31'h0, vecs[i].b0_nb});
      exp_q.push_back('{vecs[i].name, vecs[i].busy_after, vecs[i].conf_after});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard underflow", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, " busy_vec"}, bp_if.busy_vec, e.busy);
        check({e.name, " busy_vec nobypass"}, nb_if.busy_vec, e.busy);
        check({e.name, " wr_conflict"}, {31'h0, bp_if.wr_conflict}, {31'h0, e.conf});
      end
      $display("txn %0d %s", i, vecs[i].name);
    end

    // Load r1..r4, reserve r2, finish with a collision on r4.
    @(negedge clk);
    drive(2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'b00, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    @(negedge clk);
    drive(2'b11, 5'd3, 5'd4, 32'h3, 32'h4, 2'b01, 5'd2, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    @(negedge clk);
    drive(2'b11, 5'd4, 5'd4, 32'h44, 32'h55, 2'b00, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    @(posedge clk);
    #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    check("preload r1", nb_rd(0), 32'h1);
    check("preload r2", nb_rd(1), 32'h2);
    check("preload r3", nb_rd(2), 32'h3);
    check("preload r4 prio", nb_rd(3), 32'h55);
    check("preload busy_vec", bp_if.busy_vec, 32'h4);
    check("preload wr_conflict", {31'h0, bp_if.wr_conflict}, 32'h1);
    $display("txn preload r1..r4");

    // Asynchronous reset between edges.
    #1;
    reset = 1'b0;
    #1;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("async reset bp rd%0d", p), bp_rd(p), 32'h0);
      check($sformatf("async reset nb rd%0d", p), nb_rd(p), 32'h0);
    end
    check("async reset busy_vec", bp_if.busy_vec, 32'h0);
    check("async reset wr_conflict", {31'h0, bp_if.wr_conflict}, 32'h0);
    $display("txn async reset");

    // Writes and reserves while reset is held must be dropped.
    drive(2'b11, 5'd1, 5'd1, 32'hFFFFFFFF, 32'hEEEEEEEE, 2'b01, 5'd1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    @(posedge clk);
    #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    check("in reset r1", bp_rd(0), 32'h0);
    check("in reset busy_vec", bp_if.busy_vec, 32'h0);
    check("in reset wr_conflict", {31'h0, bp_if.wr_conflict}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post reset r1", bp_rd(0), 32'h0);
    check("post reset busy_vec", bp_if.busy_vec, 32'h0);
    $display("txn writes during reset");

    // Normal operation resumes from the cleared state.
    @(negedge clk);
    drive(2'b01, 5'd6, 5'd0, 32'hCAFE0006, 32'h0, 2'b00, 5'd0, 5'd0, 5'd6, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd6, 5'd1, 5'd2, 5'd3);
    #1;
    check("resume r6", nb_rd(0), 32'hCAFE0006);
    check("resume r1", nb_rd(1), 32'h0);
    $display("txn resume write r6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
